pipe_mux_n: RTL

//  Parametrised N:1 datapath selector with one registered output stage.

---
 rtl/pipe_mux_n_if.sv | 41 ++++
 rtl/pipe_mux_n.sv | 92 +++++++++
 2 files changed

// File: rtl/pipe_mux_n_if.sv
// Purpose: handshake/data bundle for pipe_mux_n (N:1 registered selector).
// Signals:
//   flush      upstream -> block   squash held beat, refuse input this cycle
//   in_valid   upstream -> block   beat present
//   in_ready   block -> upstream   beat accepted this cycle (combinational)
//   sel        upstream -> block   input index, sampled with the beat
//   din        upstream -> block   packed inputs, input k = din[k*WIDTH +: WIDTH]
//   out_valid  block -> downstream dout/sel_err hold a valid beat
//   out_ready  downstream -> block beat consumed this cycle
//   dout       block -> downstream registered selected word
//   sel_err    block -> downstream registered out-of-range flag
//   err_cnt    block -> downstream saturating count of out-of-range beats
interface pipe_mux_n_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned CNT_W  = 8
);
   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        sel;
   logic [NUM_IN*WIDTH-1:0] din;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        dout;
   logic                    sel_err;
   logic [CNT_W-1:0]        err_cnt;

   // Drives the block: upstream beat source plus downstream consumer.
   modport master (
      output flush, in_valid, sel, din, out_ready,
      input  in_ready, out_valid, dout, sel_err, err_cnt
   );

   // The selector itself.
   modport slave (
      input  flush, in_valid, sel, din, out_ready,
      output in_ready, out_valid, dout, sel_err, err_cnt
   );
endinterface

// File: rtl/pipe_mux_n.sv
// Purpose: parametrised N:1 word selector with one registered output stage,
//          valid/ready handshake, stall/flush and out-of-range select detection.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   pipe_mux_n_if.slave (handshake, select, data, error outputs)
module pipe_mux_n #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned CNT_W  = 8
) (
   input logic           clk,
   input logic           rst,
   pipe_mux_n_if.slave   bus
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             sel_err_q, sel_err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic             in_ready_c;
   logic             accept_c;
   logic             sel_ok_c;
   logic [WIDTH-1:0] word_c;

   // Ready does not look at in_valid; flush blocks intake for the cycle.
   always_comb begin
      in_ready_c = !bus.flush && (!out_valid_q || bus.out_ready);
      accept_c   = bus.in_valid && in_ready_c;
   end

   // Compare one bit wider so NUM_IN == 2**SEL_W does not wrap to zero.
   // An X/Z select makes this unknown, which the if below routes to the error path.
   always_comb begin
      sel_ok_c = ({1'b0, bus.sel} < (SEL_W+1)'(NUM_IN));
   end

   // Equality-compare mux: never indexes past the last real input.
   always_comb begin
      word_c = '0;
      for (int k = 0; k < int'(NUM_IN); k++) begin
         if (bus.sel == SEL_W'(k)) word_c = bus.din[k*WIDTH +: WIDTH];
      end
   end

   // Next-state: load on accept, otherwise flush or drain clears valid.
   always_comb begin
      out_valid_d = out_valid_q;
      dout_d      = dout_q;
      sel_err_d   = sel_err_q;
      err_cnt_d   = err_cnt_q;
      if (accept_c) begin
         out_valid_d = 1'b1;
         if (sel_ok_c) begin
            dout_d    = word_c;
            sel_err_d = 1'b0;
         end else begin
            dout_d    = '0;
            sel_err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
         end
      end else if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         sel_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         dout_q      <= dout_d;
         sel_err_q   <= sel_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.dout      = dout_q;
   assign bus.sel_err   = sel_err_q;
   assign bus.err_cnt   = err_cnt_q;

endmodule
